// File: rtl/chip_audio_pkg.sv
// Shared definitions for the multi-voice CHIP-8/XO-CHIP sound unit:
// register-select codes, reset pattern bytes and a constant clog2 helper.
package chip_audio_pkg;

  typedef enum logic [1:0] {
    WR_TIMER   = 2'd0,
    WR_STEP    = 2'd1,
    WR_PATTERN = 2'd2,
    WR_RSVD    = 2'd3
  } wr_sel_e;

  localparam logic [7:0] PAT_EVEN_RESET = 8'hFF;
  localparam logic [7:0] PAT_ODD_RESET  = 8'h00;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/chip_audio_voice.sv
// One sound voice: 60 Hz countdown timer, step register, pattern RAM and
// phase accumulator whose top bits select the current pattern bit.
module chip_audio_voice
  import chip_audio_pkg::*;
#(
  parameter int                PATTERN_BYTES = 16,
  parameter int                ACC_W         = 24,
  parameter int                TIMER_W       = 8,
  parameter logic [ACC_W-1:0]  STEP_RESET    = 24'h00100,
  localparam int               IDX_W         = clog2(PATTERN_BYTES),
  localparam int               BIT_W         = clog2(PATTERN_BYTES * 8)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             wr_timer,
  input  logic             wr_step,
  input  logic             wr_pattern,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [ACC_W-1:0] wr_data,
  output logic             active,
  output logic             vbit
);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   step_q;
  logic [7:0]         pattern_q [PATTERN_BYTES];
  logic [BIT_W-1:0]   bitidx;
  logic [7:0]         cur_byte;

  assign active = (timer_q != '0);

  // A timer write on a tick cycle wins; that voice simply misses the tick.
  always_comb begin
    timer_d = timer_q;
    if (wr_timer) begin
      timer_d = wr_data[TIMER_W-1:0];
    end else if (tick && active) begin
      timer_d = timer_q - TIMER_W'(1);
    end
  end

  always_comb begin
    acc_d = '0;
    if (active) acc_d = acc_q + step_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
      acc_q   <= '0;
      step_q  <= STEP_RESET;
      for (int i = 0; i < PATTERN_BYTES; i++) begin
        pattern_q[i] <= (i % 2 == 0) ? PAT_EVEN_RESET : PAT_ODD_RESET;
      end
    end else begin
      timer_q <= timer_d;
      acc_q   <= acc_d;
      if (wr_step) step_q <= wr_data;
      if (wr_pattern) pattern_q[wr_idx] <= wr_data[7:0];
    end
  end

  // Bits play MSB first, so bit 7-n of the byte is ~n for a 3-bit offset.
  assign bitidx   = acc_q[ACC_W-1 -: BIT_W];
  assign cur_byte = pattern_q[bitidx[BIT_W-1:3]];
  assign vbit     = cur_byte[~bitidx[2:0]] & active;

endmodule

// File: rtl/chip_audio.sv
// Multi-voice sound unit top: vsync tick detect, register write decode and a
// first-order sigma-delta mixer driving the 1-bit speaker.
module chip_audio
  import chip_audio_pkg::*;
#(
  parameter int                CHANNELS      = 1,
  parameter int                PATTERN_BYTES = 16,
  parameter int                ACC_W         = 24,
  parameter int                TIMER_W       = 8,
  parameter logic [ACC_W-1:0]  STEP_RESET    = 24'h00100,
  localparam int               CH_W          = (clog2(CHANNELS) > 0) ? clog2(CHANNELS) : 1,
  localparam int               IDX_W         = clog2(PATTERN_BYTES),
  localparam int               SUM_W         = clog2(CHANNELS + 1),
  localparam int               ERR_W         = SUM_W + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                vsync,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [1:0]          wr_sel,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [ACC_W-1:0]    wr_data,
  output logic [CHANNELS-1:0] active,
  output logic                spkr
);

  logic                vsync_q;
  logic                tick;
  logic                wr_ok;
  logic [CHANNELS-1:0] vbit;
  logic [SUM_W-1:0]    sum;
  logic [ERR_W-1:0]    err_q, err_d, mix_t;
  logic                spkr_q, spkr_d;

  assign tick  = vsync & ~vsync_q;
  assign wr_ok = wr_en && (32'(wr_ch) < CHANNELS);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_voice
    logic sel_ch;
    assign sel_ch = wr_ok && (wr_ch == CH_W'(g));

    chip_audio_voice #(
      .PATTERN_BYTES(PATTERN_BYTES),
      .ACC_W        (ACC_W),
      .TIMER_W      (TIMER_W),
      .STEP_RESET   (STEP_RESET)
    ) u_voice (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .wr_timer  (sel_ch && (wr_sel_e'(wr_sel) == WR_TIMER)),
      .wr_step   (sel_ch && (wr_sel_e'(wr_sel) == WR_STEP)),
      .wr_pattern(sel_ch && (wr_sel_e'(wr_sel) == WR_PATTERN)),
      .wr_idx    (wr_idx),
      .wr_data   (wr_data),
      .active    (active[g]),
      .vbit      (vbit[g])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) sum = sum + SUM_W'(vbit[i]);
  end

  // err stays below CHANNELS, so one extra bit over the sum width is enough.
  always_comb begin
    mix_t  = err_q + ERR_W'(sum);
    spkr_d = 1'b0;
    err_d  = mix_t;
    if (mix_t >= ERR_W'(CHANNELS)) begin
      spkr_d = 1'b1;
      err_d  = mix_t - ERR_W'(CHANNELS);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
      err_q   <= '0;
      spkr_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      err_q   <= err_d;
      spkr_q  <= spkr_d;
    end
  end

  assign spkr = spkr_q;

endmodule
